// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared widths, constants and write-port record for the register write arbiter
package rf_arb_pkg;

    localparam int ADDRESS_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF    = 32;

    localparam logic [ADDRESS_WIDTH_DEF-1:0] REG_X0 = '0;

    typedef struct packed {
        logic [ADDRESS_WIDTH_DEF-1:0] ad;
        logic [DATA_WIDTH_DEF-1:0]    wd;
        logic                         we;
    } rf_wr_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - writeback, mul/div, decode and reg_file write-port signals of the arbiter
interface reg_write_arbiter_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
);
    logic                     wb_we;
    logic [ADDRESS_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]    wb_data;
    logic                     md_valid;
    logic [ADDRESS_WIDTH-1:0] md_rd;
    logic [DATA_WIDTH-1:0]    md_data;
    logic                     md_ready;
    logic                     md_issue;
    logic [ADDRESS_WIDTH-1:0] md_issue_rd;
    logic [ADDRESS_WIDTH-1:0] rs1_addr;
    logic [ADDRESS_WIDTH-1:0] rs2_addr;
    logic                     rs1_busy;
    logic                     rs2_busy;
    logic                     pipe_stall;
    logic                     sb_err;
    logic [ADDRESS_WIDTH-1:0] rf_ad3;
    logic [DATA_WIDTH-1:0]    rf_wd3;
    logic                     rf_we3;

    modport slave (
        input  wb_we, wb_rd, wb_data, md_valid, md_rd, md_data,
               md_issue, md_issue_rd, rs1_addr, rs2_addr,
        output md_ready, rs1_busy, rs2_busy, pipe_stall, sb_err,
               rf_ad3, rf_wd3, rf_we3
    );

    modport master (
        output wb_we, wb_rd, wb_data, md_valid, md_rd, md_data,
               md_issue, md_issue_rd, rs1_addr, rs2_addr,
        input  md_ready, rs1_busy, rs2_busy, pipe_stall, sb_err,
               rf_ad3, rf_wd3, rf_we3
    );

endinterface

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending mul/div write scoreboard with operand lookups and sticky issue error
module wb_scoreboard #(
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [ADDRESS_WIDTH-1:0] set_rd,
    input  logic                     clr_en,
    input  logic [ADDRESS_WIDTH-1:0] clr_rd,
    input  logic [ADDRESS_WIDTH-1:0] rs1_addr,
    input  logic [ADDRESS_WIDTH-1:0] rs2_addr,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic                     sb_err
);

    localparam int NREGS = 1 << ADDRESS_WIDTH;

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             err_set;

    // Set is applied after clear so a same-register issue on the accept cycle keeps the bit.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_rd] = 1'b0;
        if (set_en) busy_nxt[set_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    assign err_set  = set_en && busy[set_rd] && !(clr_en && (clr_rd == set_rd));
    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= '0;
            sb_err <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (err_set) sb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - shares the reg_file write port between writeback and the mul/div unit
module reg_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int STARVE_LIMIT  = 4
) (
    input logic                clk,
    input logic                rst,
    reg_write_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       wb_eff;
    logic       md_acc;
    logic [3:0] wait_cnt;
    rf_wr_t     wr;

    assign wb_eff       = bus.wb_we && (bus.wb_rd != REG_X0);
    assign bus.md_ready = !wb_eff;
    assign md_acc       = bus.md_valid && !wb_eff;

    always_comb begin
        wr = '0;
        if (wb_eff) begin
            wr.ad = bus.wb_rd;
            wr.wd = bus.wb_data;
            wr.we = 1'b1;
        end else if (md_acc) begin
            wr.ad = bus.md_rd;
            wr.wd = bus.md_data;
            wr.we = (bus.md_rd != REG_X0);
        end
    end

    assign bus.rf_ad3 = ADDRESS_WIDTH'(wr.ad);
    assign bus.rf_wd3 = DATA_WIDTH'(wr.wd);
    assign bus.rf_we3 = wr.we;

    // Saturates so a pipeline that ignores pipe_stall keeps it asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!bus.md_valid || md_acc) begin
            wait_cnt <= '0;
        end else if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign bus.pipe_stall = (wait_cnt == LIMIT);

    wb_scoreboard #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (bus.md_issue && (bus.md_issue_rd != REG_X0)),
        .set_rd  (bus.md_issue_rd),
        .clr_en  (md_acc),
        .clr_rd  (bus.md_rd),
        .rs1_addr(bus.rs1_addr),
        .rs2_addr(bus.rs2_addr),
        .rs1_busy(bus.rs1_busy),
        .rs2_busy(bus.rs2_busy),
        .sb_err  (bus.sb_err)
    );

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

    localparam int LIMIT = 4;

    logic clk;
    logic rst;

    reg_write_arbiter_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) bus ();

    reg_write_arbiter #(
        .ADDRESS_WIDTH(5),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rf_mem [32];
    always @(posedge clk) if (bus.rf_we3) rf_mem[bus.rf_ad3] <= bus.rf_wd3;

    // Reference model: set of pending registers, age of the current waiting result, sticky error
    bit mbusy [32];
    int mage;
    bit merr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            mage = 0;
            merr = 1'b0;
        end else begin
            bit eff, acc, iss;
            eff = bus.wb_we && (bus.wb_rd != 0);
            acc = bus.md_valid && !eff;
            iss = bus.md_issue && (bus.md_issue_rd != 0);
            if (iss && mbusy[bus.md_issue_rd] && !(acc && bus.md_rd == bus.md_issue_rd))
                merr = 1'b1;
            if (acc) mbusy[bus.md_rd] = 1'b0;
            if (iss) mbusy[bus.md_issue_rd] = 1'b1;
            mage = (bus.md_valid && !acc) ? mage + 1 : 0;
        end
    end

    always @(negedge clk) begin
        bit eff, acc;
        logic [4:0]  e_ad;
        logic [31:0] e_wd;
        logic        e_we;
        eff  = bus.wb_we && (bus.wb_rd != 0);
        acc  = bus.md_valid && !eff;
        e_ad = 0; e_wd = 0; e_we = 0;
        if (eff) begin
            e_ad = bus.wb_rd; e_wd = bus.wb_data; e_we = 1;
        end else if (acc) begin
            e_ad = bus.md_rd; e_wd = bus.md_data; e_we = (bus.md_rd != 0);
        end
        chk("m_md_ready",   32'(bus.md_ready),   32'(!eff));
        chk("m_rf_ad3",     32'(bus.rf_ad3),     32'(e_ad));
        chk("m_rf_wd3",     bus.rf_wd3,          e_wd);
        chk("m_rf_we3",     32'(bus.rf_we3),     32'(e_we));
        chk("m_pipe_stall", 32'(bus.pipe_stall), 32'(mage >= LIMIT));
        chk("m_rs1_busy",   32'(bus.rs1_busy),   32'(mbusy[bus.rs1_addr]));
        chk("m_rs2_busy",   32'(bus.rs2_busy),   32'(mbusy[bus.rs2_addr]));
        chk("m_sb_err",     32'(bus.sb_err),     32'(merr));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0;
        bus.md_valid = 0; bus.md_rd = 0; bus.md_data = 0;
        bus.md_issue = 0; bus.md_issue_rd = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.rs1_addr = 0;
        bus.rs2_addr = 0;
        step(); step();
        #1;
        chk("rst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
        chk("rst_sb_err",     32'(bus.sb_err),     32'd0);
        chk("rst_md_ready",   32'(bus.md_ready),   32'd1);
        step();
        rst = 1'b0;
        step();

        // pipeline only
        bus.wb_we = 1; bus.wb_rd = 5; bus.wb_data = 32'hDEADBEEF;
        #2;
        chk("wb_we3",   32'(bus.rf_we3), 32'd1);
        chk("wb_ad3",   32'(bus.rf_ad3), 32'd5);
        chk("wb_wd3",   bus.rf_wd3,      32'hDEADBEEF);
        chk("wb_ready", 32'(bus.md_ready), 32'd0);
        step();
        bus.wb_rd = 0;
        #2;
        chk("x0_we3",   32'(bus.rf_we3),   32'd0);
        chk("x0_ready", 32'(bus.md_ready), 32'd1);
        step();
        idle();

        // mul/div alone
        bus.md_issue = 1; bus.md_issue_rd = 10; bus.rs1_addr = 10;
        #2;
        chk("iss_busy_same", 32'(bus.rs1_busy), 32'd0);
        step();
        idle();
        #2;
        chk("iss_busy_next", 32'(bus.rs1_busy), 32'd1);
        step();
        bus.md_valid = 1; bus.md_rd = 10; bus.md_data = 42;
        #2;
        chk("md_ready",     32'(bus.md_ready), 32'd1);
        chk("md_we3",       32'(bus.rf_we3),   32'd1);
        chk("md_busy_held", 32'(bus.rs1_busy), 32'd1);
        step();
        idle();
        #2;
        chk("a0_value",   rf_mem[10],       32'd42);
        chk("a0_cleared", 32'(bus.rs1_busy), 32'd0);
        step();

        // contention: pipeline writes every cycle while the result is held
        bus.md_valid = 1; bus.md_rd = 12; bus.md_data = 32'h1234;
        bus.rs2_addr = 12;
        for (int k = 1; k <= 6; k++) begin
            bus.wb_we = 1; bus.wb_rd = 6; bus.wb_data = 32'(k);
            #2;
            chk("cont_stall", 32'(bus.pipe_stall), 32'(k >= 5));
            chk("cont_ready", 32'(bus.md_ready),   32'd0);
            chk("cont_ad3",   32'(bus.rf_ad3),     32'd6);
            step();
        end
        bus.wb_we = 0;
        #2;
        chk("stall_ready", 32'(bus.md_ready),   32'd1);
        chk("stall_ad3",   32'(bus.rf_ad3),     32'd12);
        chk("stall_held",  32'(bus.pipe_stall), 32'd1);
        step();
        idle();
        #2;
        chk("stall_fall", 32'(bus.pipe_stall), 32'd0);
        chk("cont_wd",    rf_mem[12],          32'h1234);
        step();

        // simultaneous accept and re-issue of x7
        bus.md_issue = 1; bus.md_issue_rd = 7;
        step();
        bus.md_valid = 1; bus.md_rd = 7; bus.md_data = 77;
        step();
        idle();
        bus.rs1_addr = 7;
        #2;
        chk("same_busy7", 32'(bus.rs1_busy), 32'd1);
        chk("same_err",   32'(bus.sb_err),   32'd0);
        bus.md_valid = 1; bus.md_rd = 7;
        step();
        idle();

        // double issue to x3 with no clear
        bus.md_issue = 1; bus.md_issue_rd = 3;
        step(); step();
        idle();
        #2;
        chk("err_set", 32'(bus.sb_err), 32'd1);
        bus.md_valid = 1; bus.md_rd = 3;
        step();
        idle();
        step(); step();
        chk("err_sticky", 32'(bus.sb_err), 32'd1);

        // reset in the middle of a wait with only x10 pending
        bus.md_issue = 1; bus.md_issue_rd = 10;
        step();
        idle();
        bus.md_valid = 1; bus.md_rd = 9; bus.md_data = 99;
        bus.wb_we = 1; bus.wb_rd = 4; bus.wb_data = 32'h44;
        bus.rs1_addr = 10;
        step(); step(); step();
        chk("pre_rst_stall", 32'(bus.pipe_stall), 32'd0);
        chk("pre_rst_busy",  32'(bus.rs1_busy),   32'd1);
        rst = 1'b1;
        #1;
        chk("rst_stall_now", 32'(bus.pipe_stall), 32'd0);
        chk("rst_busy_now",  32'(bus.rs1_busy),   32'd0);
        chk("rst_err_now",   32'(bus.sb_err),     32'd0);
        step();
        rst = 1'b0;
        bus.wb_we = 0;
        #2;
        chk("post_rst_ready", 32'(bus.md_ready), 32'd1);
        chk("post_rst_ad3",   32'(bus.rf_ad3),   32'd9);
        step();
        idle();
        #2;
        chk("post_rst_wd", rf_mem[9], 32'd99);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the register file's single write port (AD3/WD3/WE3) between the in-order pipeline writeback and a multi-cycle mul/div unit. It also keeps a per-register pending-write scoreboard so decode can stall on operands the mul/div unit has not yet written. It sits between the writeback stage, the mul/div unit and `reg_file`, and drives the write-port inputs of `reg_file` directly.

## Interface
- `ADDRESS_WIDTH`, 5, register address width (32 registers)
- `DATA_WIDTH`, 32, register data width
- `STARVE_LIMIT`, 4, cycles the mul/div result may wait before the pipeline is stalled (legal range 1..15)

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `wb_we`  in  1  pipeline writeback enable
- `wb_rd`  in  ADDRESS_WIDTH  pipeline destination register
- `wb_data`  in  DATA_WIDTH  pipeline write data
- `md_valid`  in  1  mul/div result valid; held with rd/data until accepted
- `md_rd`  in  ADDRESS_WIDTH  mul/div destination register
- `md_data`  in  DATA_WIDTH  mul/div result
- `md_ready`  out  1  mul/div result accepted this cycle when high with `md_valid`
- `md_issue`  in  1  mul/div op issued this cycle
- `md_issue_rd`  in  ADDRESS_WIDTH  destination of the issued op
- `rs1_addr`, `rs2_addr`  in  ADDRESS_WIDTH  decode operand addresses
- `rs1_busy`, `rs2_busy`  out  1  operand has a pending mul/div write
- `pipe_stall`  out  1  pipeline must hold `wb_we` low this cycle
- `sb_err`  out  1  sticky: issue to an already-busy register
- `rf_ad3`  out  ADDRESS_WIDTH  to `reg_file` AD3
- `rf_wd3`  out  DATA_WIDTH  to `reg_file` WD3
- `rf_we3`  out  1  to `reg_file` WE3

## Operation
- A pipeline write is effective when `wb_we && wb_rd != 0`. A write to x0 is treated as no request.
- Priority: an effective pipeline write wins. Otherwise `md_ready = 1`, and the mul/div result is granted when `md_valid` is high.
- `md_ready` = !(effective pipeline write). It is combinational and independent of `md_valid`.
- Port mux:
  - Pipeline grant: `rf_*` = {`wb_rd`, `wb_data`, 1}.
  - Mul/div grant: `rf_*` = {`md_rd`, `md_data`, `md_rd != 0`}.
  - No grant: `rf_*` = {0, 0, 0}.
- Starvation counter `wait_cnt`:
  - Increments each cycle `md_valid && !md_ready`.
  - Saturates at `STARVE_LIMIT`.
  - Clears on accept or when `md_valid` is low.
- `pipe_stall` = (`wait_cnt == STARVE_LIMIT`), decoded from the register.
- If the pipeline asserts `wb_we` during `pipe_stall` anyway, the pipeline still wins and `wait_cnt` stays saturated.
- Scoreboard, `busy[31:0]`:
  - `md_issue` with `md_issue_rd != 0` sets the busy bit.
  - A mul/div accept clears `busy[md_rd]`.
  - If set and clear target the same register in the same cycle, set wins.
  - `busy[0]` is constant 0.
- `rs1_busy` / `rs2_busy` = `busy[rsN_addr]`, combinational from the register. A register stays busy during its write cycle; `reg_file` and `busy` update on the same edge.
- `sb_err` sets when `md_issue` targets a register whose busy bit is already high and which is not being cleared that cycle. It clears only on reset.

## Timing
- Arbitration and mux are zero latency (combinational). Port outputs reflect inputs in the same cycle.
- The register file sees a write one edge after the grant. A `busy` clear takes effect on the same edge.
- Reset, asynchronous: `busy = 0`, `wait_cnt = 0`, `sb_err = 0`, `pipe_stall = 0`.
  - Combinational outputs follow their inputs during reset.
  - A result held across reset is accepted normally afterwards.
- Worst-case mul/div wait when the pipeline obeys `pipe_stall`: `STARVE_LIMIT + 1` cycles from `md_valid` rising to accept.

## Structure
- Package `rf_arb_pkg`:
  - `ADDRESS_WIDTH` and `DATA_WIDTH` defaults
  - `REG_X0` constant
  - `rf_wr_t` struct {ad, wd, we} for the port mux
- Sub-module `wb_scoreboard`: the busy vector, two read lookups and `sb_err`. The arbiter top holds the priority mux and `wait_cnt`.

## Test plan
- Pipeline only:
  - `wb_we=1`, `wb_rd=5`, `wb_data=0xDEADBEEF` -> `rf_we3=1`, `rf_ad3=5`, `rf_wd3=0xDEADBEEF`.
  - `wb_rd=0` -> `rf_we3=0` and `md_ready=1`.
- Mul/div alone:
  - `md_issue` rd=10 -> `rs1_busy` is 1 for `rs1_addr=10` from the next cycle.
  - `md_valid` rd=10, data=42 -> `md_ready=1`, `rf_we3=1`.
  - The `reg_file` a0 output reads 42 after the edge, and `rs1_busy` drops on the same edge.
- Contention with `STARVE_LIMIT=4`:
  - Pipeline writes every cycle while `md_valid` is held.
  - `pipe_stall` rises on the 5th cycle of waiting.
  - Pipeline drops `wb_we` -> mul/div accepted that cycle and `pipe_stall` falls the next cycle.
- Simultaneous accept of rd=7 and `md_issue` rd=7 -> `busy[7]` stays 1 and `sb_err` stays 0.
- `md_issue` to a busy rd=3 with no clear -> `sb_err=1`, and it persists until `rst`.
- Assert `rst` mid-wait with `wait_cnt=3` and `busy=0x400`:
  - Immediately: `pipe_stall=0`, `busy=0`.
  - After release: the held result is accepted.
